// File: rtl/ram_delay_line.sv
// Multi-channel circular sample buffer: one ring of 2**AWIDTH samples per channel, read by delay.
// Optional macro RAM_DELAY_LINE_ZERO_FILL_EN: reads older than the channel fill return zero.
module ram_delay_line #(
    parameter int unsigned DWIDTH   = 16,
    parameter int unsigned AWIDTH   = 9,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned OUT_REG  = 0,
    localparam int unsigned CWIDTH  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              wr_valid_i,
    input  logic [CWIDTH-1:0] wr_ch_i,
    input  logic [DWIDTH-1:0] wr_data_i,
    input  logic              flush_i,
    input  logic [CWIDTH-1:0] flush_ch_i,
    input  logic              rd_req_i,
    input  logic [CWIDTH-1:0] rd_ch_i,
    input  logic [AWIDTH-1:0] rd_delay_i,
    output logic              rd_valid_o,
    output logic [DWIDTH-1:0] rd_data_o,
    output logic              rd_oor_o
);

    localparam int unsigned DEPTH  = 2 ** AWIDTH;
    localparam int unsigned WORDS  = CHANNELS * DEPTH;
    localparam int unsigned MAXD   = DEPTH - 2;
    localparam int unsigned MWIDTH = CWIDTH + AWIDTH;

    logic [DWIDTH-1:0] mem [WORDS];

    logic [AWIDTH-1:0] wr_ptr   [CHANNELS];
    logic [AWIDTH-1:0] fill     [CHANNELS];
    logic [AWIDTH-1:0] fill_nxt [CHANNELS];

    logic              wr_ch_ok;
    logic              rd_ch_ok;
    logic [AWIDTH-1:0] wr_ptr_sel;
    logic [AWIDTH-1:0] rd_ptr_sel;
    logic [MWIDTH-1:0] wr_addr;
    logic [MWIDTH-1:0] rd_addr;
    logic              rd_oor;
    logic              rd_zero;

    logic              s1_valid;
    logic [DWIDTH-1:0] s1_data;
    logic              s1_oor;

    // Channel decode and pointer selection; all reads use pre-update pointer and fill
    always_comb begin
        wr_ch_ok   = 32'(wr_ch_i) < CHANNELS;
        rd_ch_ok   = 32'(rd_ch_i) < CHANNELS;
        wr_ptr_sel = '0;
        rd_ptr_sel = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (wr_ch_i == CWIDTH'(c)) wr_ptr_sel = wr_ptr[c];
            if (rd_ch_i == CWIDTH'(c)) rd_ptr_sel = wr_ptr[c];
        end
        wr_addr = {wr_ch_i, wr_ptr_sel};
        rd_addr = {(rd_ch_ok ? rd_ch_i : CWIDTH'(0)),
                   AWIDTH'(rd_ptr_sel - AWIDTH'(1) - rd_delay_i)};
        rd_oor  = !rd_ch_ok || (rd_delay_i > AWIDTH'(MAXD));
    end

`ifdef RAM_DELAY_LINE_ZERO_FILL_EN
    logic [AWIDTH-1:0] rd_fill_sel;

    always_comb begin
        rd_fill_sel = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (rd_ch_i == CWIDTH'(c)) rd_fill_sel = fill[c];
        end
        rd_zero = rd_delay_i >= rd_fill_sel;
    end
`else
    assign rd_zero = 1'b0;
`endif

    // Flush clears first so a same-cycle write on that channel leaves fill at 1
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            fill_nxt[c] = fill[c];
            if (flush_i && flush_ch_i == CWIDTH'(c)) fill_nxt[c] = '0;
            if (wr_valid_i && wr_ch_i == CWIDTH'(c) && fill_nxt[c] != AWIDTH'(DEPTH - 1))
                fill_nxt[c] = fill_nxt[c] + AWIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wr_ptr[c] <= '0;
                fill[c]   <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (wr_valid_i && wr_ch_i == CWIDTH'(c)) wr_ptr[c] <= wr_ptr[c] + AWIDTH'(1);
                fill[c] <= fill_nxt[c];
            end
        end
    end

    // Sample storage, not reset
    always_ff @(posedge clk_i) begin
        if (wr_valid_i && wr_ch_ok) mem[wr_addr] <= wr_data_i;
    end

    // Read stage: memory is always read, result replaced by zero when out of range or unfilled
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_oor   <= 1'b0;
        end else begin
            s1_valid <= rd_req_i;
            if (rd_req_i) begin
                s1_oor  <= rd_oor;
                s1_data <= (rd_oor || rd_zero) ? '0 : mem[rd_addr];
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            always_ff @(posedge clk_i or negedge arst_n_i) begin
                if (!arst_n_i) begin
                    rd_valid_o <= 1'b0;
                    rd_data_o  <= '0;
                    rd_oor_o   <= 1'b0;
                end else begin
                    rd_valid_o <= s1_valid;
                    if (s1_valid) begin
                        rd_data_o <= s1_data;
                        rd_oor_o  <= s1_oor;
                    end
                end
            end
        end else begin : g_no_out_reg
            assign rd_valid_o = s1_valid;
            assign rd_data_o  = s1_data;
            assign rd_oor_o   = s1_oor;
        end
    endgenerate

endmodule

// File: tb/tb_ram_delay_line.sv
// Bench for ram_delay_line: two instances (OUT_REG 0 and 1) share stimulus; a history-queue
// model predicts each tap, scoreboard entries carry the cycle they are due in.
module tb_ram_delay_line;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 3;
    localparam int unsigned CH    = 2;
    localparam int unsigned CW    = 1;
    localparam int unsigned DEPTH = 8;

    logic          clk;
    logic          arst_n;
    logic          wr_valid;
    logic [CW-1:0] wr_ch;
    logic [DW-1:0] wr_data;
    logic          flush;
    logic [CW-1:0] flush_ch;
    logic          rd_req;
    logic [CW-1:0] rd_ch;
    logic [AW-1:0] rd_delay;

    logic          v0, v1;
    logic [DW-1:0] d0, d1;
    logic          o0, o1;

    typedef struct {
        int          cyc;
        logic [DW-1:0] data;
        logic        oor;
        bit          chk;
    } exp_t;

    exp_t sb [2][$];
    int   hist [2][$];
    int   fill_m [2];
    int   n_err = 0;
    int   n_chk = 0;
    int   cyc   = 0;

    ram_delay_line #(.DWIDTH(DW), .AWIDTH(AW), .CHANNELS(CH), .OUT_REG(0)) u_dut0 (
        .clk_i(clk), .arst_n_i(arst_n),
        .wr_valid_i(wr_valid), .wr_ch_i(wr_ch), .wr_data_i(wr_data),
        .flush_i(flush), .flush_ch_i(flush_ch),
        .rd_req_i(rd_req), .rd_ch_i(rd_ch), .rd_delay_i(rd_delay),
        .rd_valid_o(v0), .rd_data_o(d0), .rd_oor_o(o0)
    );

    ram_delay_line #(.DWIDTH(DW), .AWIDTH(AW), .CHANNELS(CH), .OUT_REG(1)) u_dut1 (
        .clk_i(clk), .arst_n_i(arst_n),
        .wr_valid_i(wr_valid), .wr_ch_i(wr_ch), .wr_data_i(wr_data),
        .flush_i(flush), .flush_ch_i(flush_ch),
        .rd_req_i(rd_req), .rd_ch_i(rd_ch), .rd_delay_i(rd_delay),
        .rd_valid_o(v1), .rd_data_o(d1), .rd_oor_o(o1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            hist[c].delete();
            fill_m[c] = 0;
            sb[c].delete();
        end
    endtask

    // One clock of stimulus; the tap expectation is taken before this cycle's write/flush
    task automatic step(input bit wr, input int wch, input int wdata,
                        input bit fl, input int fch,
                        input bit rq, input int rch, input int rd);
        exp_t e;
        @(posedge clk);
        #1;
        wr_valid = wr;
        wr_ch    = CW'(wch);
        wr_data  = DW'(wdata);
        flush    = fl;
        flush_ch = CW'(fch);
        rd_req   = rq;
        rd_ch    = CW'(rch);
        rd_delay = AW'(rd);
        if (rq) begin
            e.chk  = 1'b1;
            e.oor  = 1'b0;
            e.data = '0;
            if (rd > DEPTH - 2) e.oor = 1'b1;
`ifdef RAM_DELAY_LINE_ZERO_FILL_EN
            else if (rd >= fill_m[rch]) e.data = '0;
`endif
            else if (rd < hist[rch].size()) e.data = DW'(hist[rch][rd]);
            else e.chk = 1'b0;
            e.cyc = cyc + 1;
            sb[0].push_back(e);
            e.cyc = cyc + 2;
            sb[1].push_back(e);
        end
        if (fl) fill_m[fch] = 0;
        if (wr) begin
            hist[wch].push_front(wdata & 16'hffff);
            if (hist[wch].size() > DEPTH) void'(hist[wch].pop_back());
            if (fill_m[wch] < DEPTH - 1) fill_m[wch]++;
        end
    endtask

    task automatic wr_s(input int ch, input int data);
        step(1'b1, ch, data, 1'b0, 0, 1'b0, 0, 0);
    endtask

    task automatic rd_s(input int ch, input int d);
        step(1'b0, 0, 0, 1'b0, 0, 1'b1, ch, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 0, 1'b0, 0, 0);
    endtask

    // Scoreboard monitor: valid must be high exactly in the cycle an entry is due
    always @(negedge clk) begin
        if (arst_n) begin
            for (int i = 0; i < 2; i++) begin
                logic          v;
                logic [DW-1:0] d;
                logic          o;
                bit            due;
                exp_t          e;
                v   = (i == 0) ? v0 : v1;
                d   = (i == 0) ? d0 : d1;
                o   = (i == 0) ? o0 : o1;
                due = (sb[i].size() > 0) && (sb[i][0].cyc == cyc);
                check($sformatf("dut%0d rd_valid", i), 32'(v), 32'(due));
                if (due) begin
                    e = sb[i].pop_front();
                    check($sformatf("dut%0d rd_oor", i), 32'(o), 32'(e.oor));
                    if (e.chk) check($sformatf("dut%0d rd_data", i), 32'(d), 32'(e.data));
                end
            end
        end
    end

    initial begin
        arst_n   = 1'b1;
        wr_valid = 1'b0;
        wr_ch    = '0;
        wr_data  = '0;
        flush    = 1'b0;
        flush_ch = '0;
        rd_req   = 1'b0;
        rd_ch    = '0;
        rd_delay = '0;
        #1 arst_n = 1'b0;
        #2;
        check("reset dut0 valid", 32'(v0), 0);
        check("reset dut0 data", 32'(d0), 0);
        check("reset dut0 oor", 32'(o0), 0);
        check("reset dut1 valid", 32'(v1), 0);
        check("reset dut1 data", 32'(d1), 0);
        check("reset dut1 oor", 32'(o1), 0);
        model_reset();
        @(negedge clk);
        arst_n = 1'b1;

        // Basic: taps 0..4 back-to-back
        for (int i = 1; i <= 5; i++) wr_s(0, i);
        for (int d = 0; d <= 4; d++) rd_s(0, d);
        idle(3);

        // Wrap and range limit
        for (int v = 100; v <= 119; v++) wr_s(0, v);
        rd_s(0, 6);
        rd_s(0, 7);
        idle(3);

        // Startup, flush, and flush with same-cycle write
        wr_s(1, 7);
        wr_s(1, 8);
        wr_s(1, 9);
        rd_s(1, 2);
        rd_s(1, 3);
        step(1'b0, 0, 0, 1'b1, 1, 1'b0, 0, 0);
        wr_s(1, 42);
        rd_s(1, 0);
        rd_s(1, 1);
        step(1'b1, 1, 43, 1'b1, 1, 1'b0, 0, 0);
        rd_s(1, 0);
        rd_s(1, 1);
        idle(3);

        // Channel isolation, read-during-write, read-during-flush
        wr_s(0, 10);
        wr_s(1, 20);
        wr_s(0, 11);
        wr_s(1, 21);
        step(1'b1, 1, 22, 1'b0, 0, 1'b1, 1, 0);
        rd_s(0, 1);
        step(1'b0, 0, 0, 1'b1, 0, 1'b1, 0, 1);
        rd_s(0, 0);
        idle(3);

        // Random mixed traffic
        for (int n = 0; n < 300; n++) begin
            step(1'($urandom % 2), int'($urandom % 2), int'($urandom_range(1, 65535)),
                 1'($urandom % 8 == 0), int'($urandom % 2),
                 1'($urandom % 4 != 0), int'($urandom % 2), int'($urandom % 8));
        end
        idle(3);

        // Reset with reads in flight
        wr_s(0, 77);
        wr_s(0, 78);
        rd_s(0, 0);
        rd_s(0, 1);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        flush    = 1'b0;
        rd_req   = 1'b1;
        rd_ch    = '0;
        rd_delay = '0;
        #1 arst_n = 1'b0;
        model_reset();
        #1;
        check("midrst dut0 valid", 32'(v0), 0);
        check("midrst dut0 data", 32'(d0), 0);
        check("midrst dut1 valid", 32'(v1), 0);
        check("midrst dut1 data", 32'(d1), 0);
        rd_req = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        wr_s(0, 5);
        rd_s(0, 0);
        rd_s(0, 1);
        idle(4);

        check("sb0 drained", 32'(sb[0].size()), 0);
        check("sb1 drained", 32'(sb[1].size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ram_delay_line.md
Name: ram_delay_line

Overview:
- Multi-channel circular sample buffer for the FIR datapath.
- Each channel owns a DEPTH-entry ring in one simple dual-port memory array.
- Writes append one sample to the addressed channel.
- Reads fetch the sample written d samples ago on a channel; the FIR tap engine issues one tap read per cycle.
- Successor of the plain simple dual-port RAM: adds channels, relative (delay) addressing, per-channel fill tracking, flush, range checking and optional output pipelining.

Parameters:
- DWIDTH, 16, sample width.
- AWIDTH, 9, per-channel address width; DEPTH = 2**AWIDTH; AWIDTH >= 2.
- CHANNELS, 2, number of independent rings; total memory CHANNELS*DEPTH words.
- CWIDTH, CHANNELS>1 ? $clog2(CHANNELS) : 1, channel index width (derived, not overridden).
- OUT_REG, 0, 0: read latency 1; 1: extra output register, read latency 2.

Ports:
- clk_i  in  1  clock
- arst_n_i  in  1  asynchronous active-low reset
- wr_valid_i  in  1  append wr_data_i to channel wr_ch_i
- wr_ch_i  in  CWIDTH  write channel
- wr_data_i  in  DWIDTH  sample
- flush_i  in  1  clear fill count of channel flush_ch_i
- flush_ch_i  in  CWIDTH  flush channel
- rd_req_i  in  1  tap read request
- rd_ch_i  in  CWIDTH  read channel
- rd_delay_i  in  AWIDTH  delay d; 0 = most recent committed sample
- rd_valid_o  out  1  rd_data_o valid
- rd_data_o  out  DWIDTH  tap sample
- rd_oor_o  out  1  request was out of range, qualified by rd_valid_o

Behaviour:
- Reset: one clock, reset asynchronous active-low. All wr_ptr[ch] = 0, fill[ch] = 0, rd_valid_o = 0, rd_data_o = 0, rd_oor_o = 0, pipeline valids = 0.
  - Memory contents are not reset.
  - Reset asserted mid-operation drops in-flight reads; outputs go to reset values immediately.
- Write: when wr_valid_i is high:
  - mem[{wr_ch_i, wr_ptr[wr_ch_i]}] <= wr_data_i.
  - wr_ptr increments modulo DEPTH (natural wrap).
  - fill increments, saturating at DEPTH-1.
- Read address: {rd_ch_i, wr_ptr[rd_ch_i] - 1 - rd_delay_i}, computed mod DEPTH.
  - Uses pointer and fill values from before any same-cycle write or flush.
  - A write and a read d=0 on the same channel in the same cycle returns the previous sample, never the one being written.
- Range: valid delays are 0..DEPTH-2. If rd_delay_i > DEPTH-2, the response has rd_oor_o = 1 and rd_data_o = 0; the memory read is still issued but its result is discarded.
  - With max d = DEPTH-2, the read address never equals a same-cycle write address, so no read-during-write hazard exists.
- Latency:
  - OUT_REG=0: rd_valid_o/rd_data_o/rd_oor_o registered, 1 cycle after rd_req_i.
  - OUT_REG=1: 2 cycles after rd_req_i.
  - Fully pipelined: one request per cycle, back-to-back, no stalls, no backpressure.
  - rd_valid_o is low in cycles with no corresponding request; rd_data_o holds its last value.
- Flush: fill[flush_ch_i] <= 0; wr_ptr is unchanged.
  - Flush and write on the same channel in the same cycle: write commits, fill ends at 1.
  - Flush and read in the same cycle: the read sees the pre-flush fill.
- Channels are fully isolated: traffic on one channel never alters another channel's pointer, fill or data.
- Channel index >= CHANNELS: write ignored, flush ignored; read responds with rd_oor_o = 1 and data 0.

Optional Feature:
- Macro: RAM_DELAY_LINE_ZERO_FILL_EN.
- Defined: an in-range read with rd_delay_i >= fill[rd_ch_i] (pre-write) returns rd_data_o = 0, rd_oor_o = 0. Gives clean FIR startup and post-flush behaviour. Requires fill tracking through the read pipeline.
- Undefined: such reads return raw memory contents (stale or uninitialised). Fill counters are still maintained, but fill does not affect read data.

Test Plan:
- Config for all scenarios: DWIDTH=16, AWIDTH=3 (DEPTH 8), CHANNELS=2, OUT_REG=0 unless stated.
1. Basic: write ch0 samples 1,2,3,4,5; read ch0 d=0..4 back-to-back -> rd_data_o 5,4,3,2,1 on consecutive cycles, each 1 cycle after its request, rd_valid_o high 5 cycles.
2. Wrap/range: write ch0 100..119; read d=6 -> 113; d=7 -> rd_oor_o=1, data 0; repeat with OUT_REG=1 -> same data at 2-cycle latency.
3. Zero-fill (macro defined): after reset write ch1 7,8,9; read ch1 d=2 -> 7; d=3 -> 0, oor 0. Flush ch1, write 42, read d=0 -> 42, d=1 -> 0.
4. Isolation/concurrency: interleave ch0 10,11 and ch1 20,21; read ch1 d=0 in the same cycle as writing ch1 22 -> 21; then read ch0 d=1 -> 10.
5. Reset mid-operation: issue read ch0 d=0, drop arst_n_i in the same cycle -> rd_valid_o=0, rd_data_o=0 without waiting for a clock. After release, write 5 then read d=0 -> 5, with wr_ptr back at 0.
